// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        DMEM_WAIT = 2'd2,
        HALTED    = 2'd3
    } hz_state_t;

    // Bit positions of each pipeline latch in the stall/flush vectors
    localparam int IFID = 0;
    localparam int IDEX = 1;
    localparam int XMEM = 2;
    localparam int WB   = 3;

    localparam int DEF_REG_W = 5;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller bundle: pipeline status in, latch controls out.
interface hazard_ctrl_unit_if #(
    parameter int REG_W = hazard_pkg::DEF_REG_W
);

    logic             ihit;
    logic             dhit;
    logic             xmem_memacc;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rd;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             ifid_uses_rt;
    logic             br_taken;
    logic             jump;
    logic             halt;

    logic stall_ifid, stall_idex, stall_xmem, stall_wb;
    logic flush_ifid, flush_idex, flush_xmem, flush_wb;
    logic pc_en;

    // master is the pipeline datapath; slave is the hazard controller.
    // There is no handshake: every signal is sampled level-wise each cycle.
    modport master (
        output ihit, dhit, xmem_memacc, idex_memread, idex_rd, ifid_rs, ifid_rt,
               ifid_uses_rt, br_taken, jump, halt,
        input  stall_ifid, stall_idex, stall_xmem, stall_wb,
               flush_ifid, flush_idex, flush_xmem, flush_wb, pc_en
    );

    modport slave (
        input  ihit, dhit, xmem_memacc, idex_memread, idex_rd, ifid_rs, ifid_rt,
               ifid_uses_rt, br_taken, jump, halt,
        output stall_ifid, stall_idex, stall_xmem, stall_wb,
               flush_ifid, flush_idex, flush_xmem, flush_wb, pc_en
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stateful hazard controller for the 5-stage pipeline: load-use, memory waits,
// redirects and halt, plus saturating stall/flush counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_W     = DEF_REG_W,
    parameter int LU_CYCLES = 1,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    hazard_ctrl_unit_if.slave hz,
    output hz_state_t        hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);

    hz_state_t        state;
    logic [2:0]       lu_cnt;
    logic             redirect_pend;

    logic [REG_W-1:0] ld_rd, id_rs, id_rt;
    logic             lu_hazard;
    logic             halt_c, dmem_c, lu_c, redir_c, run_path;
    logic [3:0]       stall, flush;
    logic             pc_en;

    assign ld_rd = hz.idex_rd;
    assign id_rs = hz.ifid_rs;
    assign id_rt = hz.ifid_rt;

    assign lu_hazard = hz.idex_memread && (ld_rd != '0) &&
                       ((ld_rd == id_rs) || (hz.ifid_uses_rt && (ld_rd == id_rt)));

    // Condition priority: halt > dmem wait > load-use > redirect > fetch wait
    always_comb begin
        halt_c   = (state == HALTED) || hz.halt;
        dmem_c   = !halt_c && !hz.dhit && ((state == DMEM_WAIT) || hz.xmem_memacc);
        lu_c     = !halt_c && !dmem_c && ((state == LU_STALL) || lu_hazard);
        run_path = !halt_c && !dmem_c && !lu_c;
        redir_c  = run_path && (hz.br_taken || hz.jump);
    end

    always_comb begin
        stall = '0;
        flush = '0;
        pc_en = 1'b0;
        if (!nRST) begin
            flush = '1;
        end else if (halt_c) begin
            stall = '1;
        end else if (dmem_c) begin
            stall[IFID] = 1'b1;
            stall[IDEX] = 1'b1;
            stall[XMEM] = 1'b1;
            flush[WB]   = 1'b1;
        end else if (lu_c) begin
            stall[IFID] = 1'b1;
            flush[IDEX] = 1'b1;
        end else begin
            // A redirect loads the target even while a fetch is outstanding
            pc_en       = redir_c || hz.ihit;
            flush[IFID] = redir_c || !hz.ihit || redirect_pend;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state         <= RUN;
            lu_cnt        <= '0;
            redirect_pend <= 1'b0;
        end else begin
            if (run_path) begin
                redirect_pend <= !hz.ihit && (redir_c || redirect_pend);
            end

            if (halt_c) begin
                state  <= HALTED;
                lu_cnt <= '0;
            end else if (dmem_c) begin
                state  <= DMEM_WAIT;
                lu_cnt <= '0;
            end else if (lu_c && (state == LU_STALL)) begin
                // lu_cnt counts the LU_STALL cycles still owed after this one plus one
                state  <= (lu_cnt <= 3'd1) ? RUN : LU_STALL;
                lu_cnt <= (lu_cnt == 3'd0) ? 3'd0 : lu_cnt - 3'd1;
            end else if (lu_c) begin
                state  <= (LU_INIT != 3'd0) ? LU_STALL : RUN;
                lu_cnt <= LU_INIT;
            end else begin
                state  <= RUN;
                lu_cnt <= '0;
            end
        end
    end

    assign hz_state = state;

    assign hz.stall_ifid = stall[IFID];
    assign hz.stall_idex = stall[IDEX];
    assign hz.stall_xmem = stall[XMEM];
    assign hz.stall_wb   = stall[WB];
    assign hz.flush_ifid = flush[IFID];
    assign hz.flush_idex = flush[IDEX];
    assign hz.flush_xmem = flush[XMEM];
    assign hz.flush_wb   = flush[WB];
    assign hz.pc_en      = pc_en;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (!pc_en),
        .cnt  (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (redir_c),
        .cnt  (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with an expected-output queue per cycle.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  localparam int REG_W = 5;
  localparam int LU_CYCLES = 2;
  localparam int CNT_W = 4;

  logic clk;
  logic n_rst;
  hz_state_t hz_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  hazard_ctrl_unit_if #(.REG_W(REG_W)) hz ();

  hazard_ctrl_unit #(
    .REG_W(REG_W),
    .LU_CYCLES(LU_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .CLK(clk),
    .nRST(n_rst),
    .hz(hz.slave),
    .hz_state(hz_state),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected row: {state, pc_en, stall{wb,xmem,idex,ifid}, flush{wb,xmem,idex,ifid}}
  function automatic logic [10:0] mk(hz_state_t s, logic pc, logic [3:0] st, logic [3:0] fl);
    return {s, pc, st, fl};
  endfunction

  // driver: inputs are already set; push expectation, compare at negedge, advance
  task automatic cyc(input string tag, input logic [10:0] e);
    logic [10:0] got;
    logic [10:0] ev;
    exp_q.push_back(e);
    @(negedge clk);
    got = {hz_state, hz.pc_en,
           hz.stall_wb, hz.stall_xmem, hz.stall_idex, hz.stall_ifid,
           hz.flush_wb, hz.flush_xmem, hz.flush_idex, hz.flush_ifid};
    ev = exp_q.pop_front();
    checks++;
    assert (got === ev) else begin
      failures++;
      $error("FAIL %s got=%03h exp=%03h", tag, got, ev);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] ev);
    checks++;
    assert (got === ev) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, ev);
    end
  endtask

  task automatic set_idle();
    hz.ihit = 1'b1;
    hz.dhit = 1'b0;
    hz.xmem_memacc = 1'b0;
    hz.idex_memread = 1'b0;
    hz.idex_rd = '0;
    hz.ifid_rs = '0;
    hz.ifid_rt = '0;
    hz.ifid_uses_rt = 1'b0;
    hz.br_taken = 1'b0;
    hz.jump = 1'b0;
    hz.halt = 1'b0;
  endtask

  initial begin
    logic [10:0] idle_v;
    logic [10:0] lu_run_v;
    logic [10:0] lu_stl_v;
    logic [10:0] dm_run_v;
    logic [10:0] dm_wait_v;
    logic [10:0] fw_v;
    idle_v    = mk(RUN, 1'b1, 4'b0000, 4'b0000);
    lu_run_v  = mk(RUN, 1'b0, 4'b0001, 4'b0010);
    lu_stl_v  = mk(LU_STALL, 1'b0, 4'b0001, 4'b0010);
    dm_run_v  = mk(RUN, 1'b0, 4'b0111, 4'b1000);
    dm_wait_v = mk(DMEM_WAIT, 1'b0, 4'b0111, 4'b1000);
    fw_v      = mk(RUN, 1'b0, 4'b0000, 4'b0001);

    // 1: reset held two cycles
    set_idle();
    n_rst = 1'b0;
    cyc("rst_c0", mk(RUN, 1'b0, 4'b0000, 4'b1111));
    cyc("rst_c1", mk(RUN, 1'b0, 4'b0000, 4'b1111));
    n_rst = 1'b1;
    cyc("idle0", idle_v);
    chk_cnt("rst_stall_cnt", stall_cnt, 4'd0);
    chk_cnt("rst_flush_cnt", flush_cnt, 4'd0);

    // 2: load-use on rs, two bubbles
    hz.idex_memread = 1'b1; hz.idex_rd = 5'd5; hz.ifid_rs = 5'd5;
    cyc("lu_entry", lu_run_v);
    cyc("lu_stall", lu_stl_v);
    set_idle();
    cyc("lu_done", idle_v);
    chk_cnt("lu_stall_cnt", stall_cnt, 4'd2);

    // 3: load to r0 and rt match without rt use are not hazards
    hz.idex_memread = 1'b1; hz.idex_rd = 5'd0; hz.ifid_rs = 5'd0;
    cyc("lu_r0", idle_v);
    hz.idex_rd = 5'd7; hz.ifid_rs = 5'd3; hz.ifid_rt = 5'd7; hz.ifid_uses_rt = 1'b0;
    cyc("lu_rt_unused", idle_v);
    set_idle();

    // 4: dmem miss for three cycles, then dhit with a coincident branch
    hz.xmem_memacc = 1'b1;
    cyc("dm_miss0", dm_run_v);
    cyc("dm_miss1", dm_wait_v);
    cyc("dm_miss2", dm_wait_v);
    hz.dhit = 1'b1; hz.br_taken = 1'b1;
    cyc("dm_hit_br", mk(DMEM_WAIT, 1'b1, 4'b0000, 4'b0001));
    set_idle();
    cyc("dm_after", idle_v);
    chk_cnt("dm_stall_cnt", stall_cnt, 4'd5);
    chk_cnt("dm_flush_cnt", flush_cnt, 4'd1);

    // 5: branch while fetch is outstanding
    hz.br_taken = 1'b1; hz.ihit = 1'b0;
    cyc("br_miss0", mk(RUN, 1'b1, 4'b0000, 4'b0001));
    hz.br_taken = 1'b0;
    cyc("br_miss1", fw_v);
    hz.ihit = 1'b1;
    cyc("br_ihit", mk(RUN, 1'b1, 4'b0000, 4'b0001));
    cyc("br_after", idle_v);
    chk_cnt("br_stall_cnt", stall_cnt, 4'd6);
    chk_cnt("br_flush_cnt", flush_cnt, 4'd2);

    // jump pre-empted by a load-use on rt, honoured once the bubbles end
    hz.jump = 1'b1; hz.idex_memread = 1'b1; hz.idex_rd = 5'd9;
    hz.ifid_rs = 5'd2; hz.ifid_rt = 5'd9; hz.ifid_uses_rt = 1'b1;
    cyc("jlu_entry", lu_run_v);
    cyc("jlu_stall", lu_stl_v);
    hz.idex_memread = 1'b0;
    cyc("jlu_jump", mk(RUN, 1'b1, 4'b0000, 4'b0001));
    set_idle();
    cyc("jlu_after", idle_v);
    chk_cnt("jlu_stall_cnt", stall_cnt, 4'd8);
    chk_cnt("jlu_flush_cnt", flush_cnt, 4'd3);

    // 6: halt with a coincident dmem miss; sticky until reset
    hz.halt = 1'b1; hz.xmem_memacc = 1'b1;
    cyc("halt_entry", mk(RUN, 1'b0, 4'b1111, 4'b0000));
    hz.halt = 1'b0; hz.dhit = 1'b1;
    cyc("halt_dhit", mk(HALTED, 1'b0, 4'b1111, 4'b0000));
    set_idle();
    cyc("halt_idle", mk(HALTED, 1'b0, 4'b1111, 4'b0000));
    chk_cnt("halt_stall_cnt", stall_cnt, 4'd11);
    n_rst = 1'b0;
    cyc("halt_rst", mk(HALTED, 1'b0, 4'b0000, 4'b1111));
    n_rst = 1'b1;
    cyc("halt_exit", idle_v);
    chk_cnt("halt_rst_cnt", stall_cnt, 4'd0);

    // 7: stall counter saturation
    hz.ihit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc("sat_fetch", fw_v);
    end
    chk_cnt("sat_stall_cnt", stall_cnt, 4'd15);
    cyc("sat_fetch_more", fw_v);
    chk_cnt("sat_stall_hold", stall_cnt, 4'd15);
    chk_cnt("sat_flush_cnt", flush_cnt, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
